instr_fetch_unit: RTL and testbench

- Producer side of the IF/ID pipeline register. It owns the PC and runs a req/ack handshake to instruction memory.
- Each fetched instruction and its PC+4 are held in a one-entry buffer and offered to IF/ID through o_we.
- It drives the IF/ID flush when a branch or jump redirect arrives, and honours decode stalls without losing or duplicating instructions.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: state encoding and fetch constants.
package mips_pkg;

    // Fetch controller states: normal fetching, or waiting to discard a stale response
    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction and its PC+4.
// Clear wins over fill, and fill wins over drain, so a response that
// arrives while the entry is being consumed replaces it without a bubble.
module fetch_buffer
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic              drain,
    input  logic              clear,
    input  logic [31:0]       fill_instr,
    input  logic [ADDR_W-1:0] fill_pc,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    logic              valid_reg;
    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] pc_reg;

    // Entry state: clear beats fill, fill beats drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= INSTR_NOP;
            pc_reg    <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            instr_reg <= fill_instr;
            pc_reg    <= fill_pc;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the req/ack handshake to instruction memory,
// buffers one response and hands it to IF/ID, and flushes IF/ID on redirect.
// A request is never withdrawn once raised; a redirect that catches one in
// flight parks in DROP until the stale response arrives and is thrown away.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_we,
    output logic              o_flush
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] drop_addr_reg, drop_addr_next;

    logic              buf_valid;
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc;
    logic              buf_fill;
    logic              buf_clear;
    logic [ADDR_W-1:0] pc_plus_inc;

    // Wraps modulo 2^ADDR_W by construction
    assign pc_plus_inc = pc_reg + ADDR_W'(PC_INC);

    // State, PC and parked request address registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= FETCH;
            pc_reg        <= RESET_PC;
            drop_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            drop_addr_reg <= drop_addr_next;
        end
    end

    // Next-state, PC update and handshake/delivery outputs; all quiet in reset
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        drop_addr_next = drop_addr_reg;
        o_imem_req     = 1'b0;
        o_imem_addr    = pc_reg;
        o_we           = 1'b0;
        o_flush        = 1'b0;
        buf_fill       = 1'b0;
        buf_clear      = 1'b0;
        if (i_rst_n) begin
            case (state_reg)
                FETCH: begin
                    o_we        = buf_valid & ~i_stall & ~i_redirect;
                    // Only ask for more when the entry is free or leaving now
                    o_imem_req  = ~buf_valid | o_we;
                    o_imem_addr = pc_reg;
                    if (i_redirect) begin
                        o_flush   = 1'b1;
                        buf_clear = 1'b1;
                        pc_next   = i_redirect_pc;
                        // An unanswered request must still be honoured at its old address
                        if (o_imem_req && !i_imem_ack) begin
                            state_next     = DROP;
                            drop_addr_next = pc_reg;
                        end
                    end else if (o_imem_req && i_imem_ack) begin
                        buf_fill = 1'b1;
                        pc_next  = pc_plus_inc;
                    end
                end
                DROP: begin
                    o_imem_req  = 1'b1;
                    o_imem_addr = drop_addr_reg;
                    if (i_redirect) begin
                        o_flush   = 1'b1;
                        buf_clear = 1'b1;
                        pc_next   = i_redirect_pc;
                    end
                    if (i_imem_ack) begin
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    fetch_buffer #(
        .ADDR_W(ADDR_W)
    ) u_fetch_buffer (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .fill      (buf_fill),
        .drain     (o_we),
        .clear     (buf_clear),
        .fill_instr(i_imem_rdata),
        .fill_pc   (pc_plus_inc),
        .valid     (buf_valid),
        .instr     (buf_instr),
        .pc        (buf_pc)
    );

    // Present zeros to IF/ID while reset is held
    assign o_instr = i_rst_n ? buf_instr : INSTR_NOP;
    assign o_pc    = i_rst_n ? buf_pc : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with the default reset PC
// and one starting at 0xFFFF_FFFC to exercise address wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst_n, stall, redirect, ack;
    logic [31:0] redirect_pc, rdata;
    logic        req, we, flush;
    logic [31:0] addr, instr, pc;

    // Wrap instance signals
    logic        rst_n_w, ack_w;
    logic [31:0] rdata_w;
    logic        req_w, we_w, flush_w;
    logic [31:0] addr_w, instr_w, pc_w;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_ack(ack), .i_imem_rdata(rdata), .o_instr(instr), .o_pc(pc),
        .o_we(we), .o_flush(flush)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n_w), .i_stall(zero_bit), .i_redirect(zero_bit),
        .i_redirect_pc(zero_word), .o_imem_req(req_w), .o_imem_addr(addr_w),
        .i_imem_ack(ack_w), .i_imem_rdata(rdata_w), .o_instr(instr_w), .o_pc(pc_w),
        .o_we(we_w), .o_flush(flush_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point and log one line for this cycle
    task automatic settle(input string name);
        @(negedge clk);
        $display("[%0t] %s req=%b addr=%h we=%b instr=%h pc=%h flush=%b",
                 $time, name, req, addr, we, instr, pc, flush);
    endtask

    // Check the main instance handshake and delivery outputs in one go
    task automatic expect_main(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_we, input logic e_flush);
        check({tag, ".req"}, {31'h0, req}, {31'h0, e_req});
        if (e_req) check({tag, ".addr"}, addr, e_addr);
        check({tag, ".we"}, {31'h0, we}, {31'h0, e_we});
        check({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0080;
        ack = 1'b1; rdata = 32'h1234_5678;
        rst_n_w = 1'b0; ack_w = 1'b0; rdata_w = 32'h0;

        // Reset cycle: everything quiet even with redirect and ack asserted
        settle("reset");
        expect_main("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst.instr", instr, 32'h0);
        check("rst.pc", pc, 32'h0);
        tick();

        // Zero-wait memory: two back-to-back responses
        rst_n = 1'b1; redirect = 1'b0; ack = 1'b1; rdata = 32'h2008_0005;
        settle("zw0");
        expect_main("zw0", 1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        ack = 1'b1; rdata = 32'h2009_0007;
        settle("zw1");
        expect_main("zw1", 1'b1, 32'h4, 1'b1, 1'b0);
        check("zw1.instr", instr, 32'h2008_0005);
        check("zw1.pc", pc, 32'h4);
        tick();
        ack = 1'b0;
        settle("zw2");
        expect_main("zw2", 1'b1, 32'h8, 1'b1, 1'b0);
        check("zw2.instr", instr, 32'h2009_0007);
        check("zw2.pc", pc, 32'h8);
        tick();

        // Three-cycle latency: request to 0x8 held until ack
        for (int i = 0; i < 2; i++) begin
            settle("lat_wait");
            expect_main("lat_wait", 1'b1, 32'h8, 1'b0, 1'b0);
            tick();
        end
        ack = 1'b1; rdata = 32'hAAAA_0001;
        settle("lat_ack");
        expect_main("lat_ack", 1'b1, 32'h8, 1'b0, 1'b0);
        tick();
        ack = 1'b0;
        settle("lat_dlv");
        expect_main("lat_dlv", 1'b1, 32'hC, 1'b1, 1'b0);
        check("lat_dlv.instr", instr, 32'hAAAA_0001);
        check("lat_dlv.pc", pc, 32'hC);
        tick();

        // Fill the buffer, then stall four cycles
        ack = 1'b1; rdata = 32'hBBBB_0002;
        settle("st_fill");
        expect_main("st_fill", 1'b1, 32'hC, 1'b0, 1'b0);
        tick();
        ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle("stall");
            expect_main("stall", 1'b0, 32'h0, 1'b0, 1'b0);
            check("stall.instr", instr, 32'hBBBB_0002);
            tick();
        end
        stall = 1'b0;
        settle("st_rel");
        expect_main("st_rel", 1'b1, 32'h10, 1'b1, 1'b0);
        check("st_rel.instr", instr, 32'hBBBB_0002);
        check("st_rel.pc", pc, 32'h10);
        tick();

        // Redirect to 0x40 while request to 0x10 is outstanding
        redirect = 1'b1; redirect_pc = 32'h40;
        settle("rd");
        expect_main("rd", 1'b1, 32'h10, 1'b0, 1'b1);
        tick();
        redirect = 1'b0;
        settle("rd_drop");
        expect_main("rd_drop", 1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        settle("rd_stale");
        expect_main("rd_stale", 1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        ack = 1'b1; rdata = 32'hCCCC_0003;
        settle("rd_new");
        expect_main("rd_new", 1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        ack = 1'b0;
        settle("rd_dlv");
        expect_main("rd_dlv", 1'b1, 32'h44, 1'b1, 1'b0);
        check("rd_dlv.instr", instr, 32'hCCCC_0003);
        check("rd_dlv.pc", pc, 32'h44);
        tick();

        // Redirect coinciding with ack and stall
        redirect = 1'b1; redirect_pc = 32'h100; ack = 1'b1; rdata = 32'hEEEE_0004; stall = 1'b1;
        settle("rak");
        expect_main("rak", 1'b1, 32'h44, 1'b0, 1'b1);
        tick();
        redirect = 1'b0; ack = 1'b0; stall = 1'b0;
        settle("rak_next");
        expect_main("rak_next", 1'b1, 32'h100, 1'b0, 1'b0);
        tick();

        // Two redirects while a request is parked: newest target wins
        redirect = 1'b1; redirect_pc = 32'h200;
        settle("dd0");
        expect_main("dd0", 1'b1, 32'h100, 1'b0, 1'b1);
        tick();
        redirect_pc = 32'h300;
        settle("dd1");
        expect_main("dd1", 1'b1, 32'h100, 1'b0, 1'b1);
        tick();
        redirect = 1'b0; ack = 1'b1; rdata = 32'h5555_0005;
        settle("dd_ack");
        expect_main("dd_ack", 1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        ack = 1'b1; rdata = 32'h1111_0006;
        settle("dd_new");
        expect_main("dd_new", 1'b1, 32'h300, 1'b0, 1'b0);
        tick();

        // Redirect with a full buffer, stalled, nothing outstanding
        ack = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
        settle("rfull");
        expect_main("rfull", 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        stall = 1'b0; redirect = 1'b0;
        settle("rfull_next");
        expect_main("rfull_next", 1'b1, 32'h500, 1'b0, 1'b0);
        tick();

        // Reset while waiting for ack: outputs drop, fetch restarts at RESET_PC
        rst_n = 1'b0;
        settle("mrst");
        expect_main("mrst", 1'b0, 32'h0, 1'b0, 1'b0);
        check("mrst.pc", pc, 32'h0);
        tick();
        rst_n = 1'b1;
        settle("mrst_rel");
        expect_main("mrst_rel", 1'b1, 32'h0, 1'b0, 1'b0);
        tick();

        // Wrap instance: start at 0xFFFF_FFFC
        rst_n_w = 1'b1; ack_w = 1'b1; rdata_w = 32'h2010_0001;
        settle("wrap0");
        check("wrap0.req", {31'h0, req_w}, 32'h1);
        check("wrap0.addr", addr_w, 32'hFFFF_FFFC);
        tick();
        ack_w = 1'b0;
        settle("wrap1");
        check("wrap1.we", {31'h0, we_w}, 32'h1);
        check("wrap1.pc", pc_w, 32'h0);
        check("wrap1.instr", instr_w, 32'h2010_0001);
        check("wrap1.addr", addr_w, 32'h0);
        tick();
        rst_n_w = 1'b0;
        settle("wrap_rst");
        check("wrap_rst.req", {31'h0, req_w}, 32'h0);
        check("wrap_rst.pc", pc_w, 32'h0);
        check("wrap_rst.flush", {31'h0, flush_w}, 32'h0);
        tick();
        rst_n_w = 1'b1;
        settle("wrap_rel");
        check("wrap_rel.req", {31'h0, req_w}, 32'h1);
        check("wrap_rel.addr", addr_w, 32'hFFFF_FFFC);
        check("wrap_rel.we", {31'h0, we_w}, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
